// File: rtl/sdram_cmd_arbiter.sv
// SDRAM command sequencer: refresh/two-port arbitration feeding closed-page
// ACT/RD/WR/PRE and REF sequences onto a registered command bus.
module sdram_cmd_arbiter #(
  parameter int TRcd      = 3,
  parameter int TCas      = 3,
  parameter int TWr       = 2,
  parameter int TRp       = 3,
  parameter int TRfc      = 9,
  parameter int BankWidth = 2,
  parameter int RowWidth  = 13,
  parameter int ColWidth  = 9,
  parameter int DataWidth = 16,
  parameter int AddrWidth = BankWidth + RowWidth + ColWidth
) (
  input  logic                   i_dram_clk,
  input  logic                   i_rst,
  input  logic                   i_init_done,
  input  logic                   i_refresh_req,
  output logic                   o_refresh_ack,
  input  logic [1:0]             i_req,
  input  logic [1:0]             i_we,
  input  logic [2*AddrWidth-1:0] i_addr,
  input  logic [2*DataWidth-1:0] i_wdata,
  output logic [1:0]             o_gnt,
  output logic [1:0]             o_rvalid,
  output logic [DataWidth-1:0]   o_rdata,
  output logic [2:0]             o_cmd,
  output logic [BankWidth-1:0]   o_ba,
  output logic [RowWidth-1:0]    o_addr,
  output logic [DataWidth-1:0]   o_wdata,
  output logic                   o_wdata_oe,
  input  logic [DataWidth-1:0]   i_rdata
);

  localparam int TMax0 = (TRcd  > TCas) ? TRcd  : TCas;
  localparam int TMax1 = (TMax0 > TWr)  ? TMax0 : TWr;
  localparam int TMax2 = (TMax1 > TRp)  ? TMax1 : TRp;
  localparam int TMax  = (TMax2 > TRfc) ? TMax2 : TRfc;
  localparam int CntW  = $clog2(TMax + 1);

  localparam logic [2:0] CMD_NOP = 3'd0;
  localparam logic [2:0] CMD_ACT = 3'd1;
  localparam logic [2:0] CMD_RD  = 3'd2;
  localparam logic [2:0] CMD_WR  = 3'd3;
  localparam logic [2:0] CMD_PRE = 3'd4;
  localparam logic [2:0] CMD_REF = 3'd5;

  typedef enum logic [2:0] {
    IDLE, ACT_WAIT, RW, CAS_WAIT, WR_REC, PRE_WAIT, REF_WAIT
  } state_e;

  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   last_q, last_d;
  logic                   port_q, port_d;
  logic                   we_q, we_d;
  logic [BankWidth-1:0]   bank_q, bank_d;
  logic [RowWidth-1:0]    row_q, row_d;
  logic [ColWidth-1:0]    col_q, col_d;
  logic [DataWidth-1:0]   wd_q, wd_d;

  logic [2:0]             cmd_q, cmd_d;
  logic [BankWidth-1:0]   ba_q, ba_d;
  logic [RowWidth-1:0]    addr_q, addr_d;
  logic [DataWidth-1:0]   wdata_q, wdata_d;
  logic                   oe_q, oe_d;
  logic [1:0]             gnt_q, gnt_d;
  logic [1:0]             rvalid_q, rvalid_d;
  logic [DataWidth-1:0]   rdata_q, rdata_d;
  logic                   ack_q, ack_d;

  logic                   expire, arb, do_pre, win;
  logic [AddrWidth-1:0]   win_addr;
  logic [DataWidth-1:0]   win_wdata;

  always_ff @(posedge i_dram_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      last_q   <= 1'b1;
      port_q   <= 1'b0;
      we_q     <= 1'b0;
      bank_q   <= '0;
      row_q    <= '0;
      col_q    <= '0;
      wd_q     <= '0;
      cmd_q    <= CMD_NOP;
      ba_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      oe_q     <= 1'b0;
      gnt_q    <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
      ack_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      port_q   <= port_d;
      we_q     <= we_d;
      bank_q   <= bank_d;
      row_q    <= row_d;
      col_q    <= col_d;
      wd_q     <= wd_d;
      cmd_q    <= cmd_d;
      ba_q     <= ba_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      oe_q     <= oe_d;
      gnt_q    <= gnt_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      ack_q    <= ack_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    port_d   = port_q;
    we_d     = we_q;
    bank_d   = bank_q;
    row_d    = row_q;
    col_d    = col_q;
    wd_d     = wd_q;
    cmd_d    = CMD_NOP;
    ba_d     = ba_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    oe_d     = 1'b0;
    gnt_d    = '0;
    rvalid_d = '0;
    rdata_d  = rdata_q;
    ack_d    = 1'b0;
    arb      = 1'b0;
    do_pre   = 1'b0;
    expire   = (cnt_q == CntW'(1));

    // Round robin: with both ports asking, the one not granted last wins.
    win       = (&i_req) ? ~last_q : i_req[1];
    win_addr  = win ? i_addr[AddrWidth +: AddrWidth] : i_addr[0 +: AddrWidth];
    win_wdata = win ? i_wdata[DataWidth +: DataWidth] : i_wdata[0 +: DataWidth];

    unique case (state_q)
      IDLE: arb = 1'b1;
      ACT_WAIT: begin
        if (expire) begin
          cmd_d   = we_q ? CMD_WR : CMD_RD;
          ba_d    = bank_q;
          addr_d  = RowWidth'(col_q);
          oe_d    = we_q;
          if (we_q) wdata_d = wd_q;
          cnt_d   = we_q ? CntW'(TWr) : CntW'(TCas);
          state_d = RW;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      RW: begin
        // Reads hold the CAS count one cycle so sampling lands at RD+TCas.
        if (!we_q) begin
          state_d = CAS_WAIT;
        end else if (expire) begin
          do_pre = 1'b1;
        end else begin
          cnt_d   = cnt_q - CntW'(1);
          state_d = WR_REC;
        end
      end
      CAS_WAIT: begin
        if (expire) begin
          rvalid_d[port_q] = 1'b1;
          rdata_d          = i_rdata;
          do_pre           = 1'b1;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      WR_REC: begin
        if (expire) do_pre = 1'b1;
        else        cnt_d  = cnt_q - CntW'(1);
      end
      PRE_WAIT, REF_WAIT: begin
        if (expire) arb   = 1'b1;
        else        cnt_d = cnt_q - CntW'(1);
      end
      default: state_d = IDLE;
    endcase

    if (do_pre) begin
      cmd_d   = CMD_PRE;
      ba_d    = bank_q;
      addr_d  = '0;
      cnt_d   = CntW'(TRp);
      state_d = PRE_WAIT;
    end

    // Arbitration on the exact cycle a wait expires gives back-to-back
    // commands at the minimum legal spacing.
    if (arb) begin
      state_d = IDLE;
      cnt_d   = '0;
      if (i_init_done && i_refresh_req) begin
        cmd_d   = CMD_REF;
        ack_d   = 1'b1;
        cnt_d   = CntW'(TRfc);
        state_d = REF_WAIT;
      end else if (i_init_done && (|i_req)) begin
        cmd_d      = CMD_ACT;
        gnt_d[win] = 1'b1;
        last_d     = win;
        port_d     = win;
        we_d       = i_we[win];
        bank_d     = win_addr[AddrWidth-1 -: BankWidth];
        row_d      = win_addr[ColWidth +: RowWidth];
        col_d      = win_addr[ColWidth-1:0];
        wd_d       = win_wdata;
        ba_d       = win_addr[AddrWidth-1 -: BankWidth];
        addr_d     = win_addr[ColWidth +: RowWidth];
        cnt_d      = CntW'(TRcd);
        state_d    = ACT_WAIT;
      end
    end
  end

  assign o_cmd         = cmd_q;
  assign o_ba          = ba_q;
  assign o_addr        = addr_q;
  assign o_wdata       = wdata_q;
  assign o_wdata_oe    = oe_q;
  assign o_gnt         = gnt_q;
  assign o_rvalid      = rvalid_q;
  assign o_rdata       = rdata_q;
  assign o_refresh_ack = ack_q;

endmodule

// File: tb/tb_sdram_cmd_arbiter.sv
// Bench for sdram_cmd_arbiter: a cycle-indexed schedule model checked every
// cycle, directed scenarios pinned with literal offsets, then random traffic.
module tb_sdram_cmd_arbiter;
  localparam int TRCD = 3, TCAS = 3, TWR = 2, TRP = 3, TRFC = 9;
  localparam int BW = 2, RW = 13, CW = 9, DW = 16, AW = BW + RW + CW;
  localparam logic [2:0] NOP = 3'd0, ACT = 3'd1, RD = 3'd2, WR = 3'd3, PRE = 3'd4, REF = 3'd5;

  logic clk, i_rst, i_init_done, i_refresh_req, o_refresh_ack;
  logic [1:0] i_req, i_we, o_gnt, o_rvalid;
  logic [2*AW-1:0] i_addr;
  logic [2*DW-1:0] i_wdata;
  logic [DW-1:0] o_rdata, o_wdata, i_rdata;
  logic [2:0] o_cmd;
  logic [BW-1:0] o_ba;
  logic [RW-1:0] o_addr;
  logic o_wdata_oe;

  sdram_cmd_arbiter #(.TRcd(TRCD), .TCas(TCAS), .TWr(TWR), .TRp(TRP), .TRfc(TRFC),
    .BankWidth(BW), .RowWidth(RW), .ColWidth(CW), .DataWidth(DW)) dut (
    .i_dram_clk(clk), .i_rst(i_rst), .i_init_done(i_init_done),
    .i_refresh_req(i_refresh_req), .o_refresh_ack(o_refresh_ack),
    .i_req(i_req), .i_we(i_we), .i_addr(i_addr), .i_wdata(i_wdata),
    .o_gnt(o_gnt), .o_rvalid(o_rvalid), .o_rdata(o_rdata), .o_cmd(o_cmd),
    .o_ba(o_ba), .o_addr(o_addr), .o_wdata(o_wdata), .o_wdata_oe(o_wdata_oe),
    .i_rdata(i_rdata));

  initial begin clk = 1'b0; forever #5 clk = ~clk; end

  int tests = 0, fails = 0, cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Expected bus contents for one cycle.
  typedef struct {
    logic [2:0] cmd; logic [1:0] gnt, rv; logic ack, oe, full;
    logic [BW-1:0] ba; logic [RW-1:0] addr; logic [DW-1:0] wd;
  } ev_t;

  typedef struct {
    int cyc; logic [2:0] cmd; logic [1:0] gnt, rv; logic ack, oe;
    logic [BW-1:0] ba; logic [RW-1:0] addr; logic [DW-1:0] rdata, wdata;
  } log_t;

  ev_t sched[int];
  log_t log_q[$];
  int next_ok = 0, last_p = 1, mp, rdc, prc;
  logic [AW-1:0] ma;
  ev_t e;

  function automatic ev_t blank(input logic [2:0] c);
    ev_t b;
    b.cmd = c; b.gnt = 0; b.rv = 0; b.ack = 0; b.oe = 0; b.full = 0;
    b.ba = 0; b.addr = 0; b.wd = 0;
    return b;
  endfunction

  // Model: each transaction is expanded into absolute-cycle events when it
  // wins arbitration; the bus is free again at PRE+tRP or REF+tRFC.
  always begin
    @(posedge clk); #1;
    cyc++;
    if (i_rst) begin
      sched.delete(); next_ok = 0; last_p = 1;
      chk("rst cmd", 32'(o_cmd), 0);     chk("rst gnt", 32'(o_gnt), 0);
      chk("rst rvalid", 32'(o_rvalid), 0); chk("rst ack", 32'(o_refresh_ack), 0);
      chk("rst oe", 32'(o_wdata_oe), 0); chk("rst ba", 32'(o_ba), 0);
      chk("rst addr", 32'(o_addr), 0);   chk("rst wdata", 32'(o_wdata), 0);
      chk("rst rdata", 32'(o_rdata), 0);
    end else begin
      if (i_init_done && cyc >= next_ok) begin
        if (i_refresh_req) begin
          e = blank(REF); e.ack = 1'b1; sched[cyc] = e;
          next_ok = cyc + TRFC;
        end else if (i_req != 2'b00) begin
          mp = (i_req == 2'b11) ? 1 - last_p : (i_req[1] ? 1 : 0);
          last_p = mp;
          ma = i_addr[mp*AW +: AW];
          e = blank(ACT); e.gnt = 2'(1 << mp); e.full = 1'b1;
          e.ba = ma[AW-1 -: BW]; e.addr = ma[CW +: RW]; sched[cyc] = e;
          rdc = cyc + TRCD;
          e = blank(i_we[mp] ? WR : RD); e.full = 1'b1; e.ba = ma[AW-1 -: BW];
          e.addr = RW'(ma[CW-1:0]); e.oe = i_we[mp]; e.wd = i_wdata[mp*DW +: DW];
          sched[rdc] = e;
          prc = i_we[mp] ? rdc + TWR : rdc + TCAS + 1;
          e = blank(PRE); e.ba = ma[AW-1 -: BW]; e.rv = i_we[mp] ? 2'b00 : 2'(1 << mp);
          sched[prc] = e;
          next_ok = prc + TRP;
        end
      end
      if (sched.exists(cyc)) begin e = sched[cyc]; sched.delete(cyc); end
      else e = blank(NOP);
      chk("cmd", 32'(o_cmd), 32'(e.cmd));
      chk("gnt", 32'(o_gnt), 32'(e.gnt));
      chk("rvalid", 32'(o_rvalid), 32'(e.rv));
      chk("refresh_ack", 32'(o_refresh_ack), 32'(e.ack));
      chk("wdata_oe", 32'(o_wdata_oe), 32'(e.oe));
      if (e.cmd inside {ACT, RD, WR, PRE}) chk("ba", 32'(o_ba), 32'(e.ba));
      if (e.full) chk("addr", 32'(o_addr), 32'(e.addr));
      if (e.cmd == PRE) chk("pre a10", 32'(o_addr[10]), 0);
      if (e.cmd == WR) chk("wdata", 32'(o_wdata), 32'(e.wd));
      if (e.rv != 2'b00) chk("rdata", 32'(o_rdata), 32'(i_rdata));
      if (o_cmd != NOP || o_gnt != 0 || o_rvalid != 0 || o_refresh_ack || o_wdata_oe)
        log_q.push_back('{cyc, o_cmd, o_gnt, o_rvalid, o_refresh_ack, o_wdata_oe,
                          o_ba, o_addr, o_rdata, o_wdata});
    end
  end

  function automatic int find_cmd(input logic [2:0] c, input int from);
    foreach (log_q[i]) if (log_q[i].cmd == c && log_q[i].cyc >= from) return log_q[i].cyc;
    return -1;
  endfunction

  function automatic log_t ent_at(input int c);
    log_t n;
    foreach (log_q[i]) if (log_q[i].cyc == c) return log_q[i];
    n = '{-1, 3'd7, 2'b00, 2'b00, 1'b0, 1'b0, '0, '0, '0, '0};
    return n;
  endfunction

  int left[2];

  task automatic drive_cycle(input bit rnd);
    @(negedge clk);
    for (int p = 0; p < 2; p++) begin
      if (i_req[p] && o_gnt[p]) begin
        if (left[p] > 0) left[p]--;
        if (rnd || left[p] == 0) i_req[p] = 1'b0;
      end
      if (rnd) begin
        if (!i_req[p]) begin
          if ($urandom_range(3) == 0) begin
            i_req[p] = 1'b1; i_we[p] = 1'($urandom);
            i_addr[p*AW +: AW] = AW'($urandom); i_wdata[p*DW +: DW] = DW'($urandom);
          end
        end else if (!o_gnt[p] && $urandom_range(49) == 0) i_req[p] = 1'b0;
      end
    end
    if (i_refresh_req && o_refresh_ack) i_refresh_req = 1'b0;
    if (rnd) begin
      i_rdata = DW'($urandom);
      if (!i_refresh_req && $urandom_range(39) == 0) i_refresh_req = 1'b1;
      if ($urandom_range(199) == 0) i_init_done = ~i_init_done;
    end
  endtask

  int t, r, n;
  int acts[$];
  logic [1:0] gs[$];
  log_t le;

  task automatic wait_act(output int tc);
    tc = -1;
    for (int k = 0; k < 20 && tc < 0; k++) begin
      drive_cycle(0);
      if (o_cmd == ACT) tc = cyc;
    end
    if (tc < 0) chk("act timeout", 0, 1);
  endtask

  initial begin
    i_rst = 1; i_init_done = 0; i_refresh_req = 0; i_req = 0; i_we = 0;
    i_addr = 0; i_wdata = 0; i_rdata = 0; left[0] = 0; left[1] = 0;
    repeat (3) @(negedge clk);
    i_rst = 0; i_init_done = 1;

    // Port0 read followed by a second pending read.
    log_q.delete(); left[0] = 2; i_we[0] = 0;
    i_addr[0 +: AW] = {2'd1, 13'h123, 9'h045}; i_rdata = 16'hBEEF; i_req[0] = 1;
    repeat (45) drive_cycle(0);
    t = find_cmd(ACT, 0); le = ent_at(t);
    chk("t1 act ba", 32'(le.ba), 1); chk("t1 act row", 32'(le.addr), 32'h123);
    chk("t1 act gnt", 32'(le.gnt), 1);
    le = ent_at(t + 3); chk("t1 rd cmd", 32'(le.cmd), 32'(RD)); chk("t1 rd col", 32'(le.addr), 32'h045);
    le = ent_at(t + 7); chk("t1 pre cmd", 32'(le.cmd), 32'(PRE));
    chk("t1 rvalid", 32'(le.rv), 1); chk("t1 rdata", 32'(le.rdata), 32'hBEEF);
    le = ent_at(t + 10); chk("t1 2nd act", 32'(le.cmd), 32'(ACT));

    // Port1 write.
    log_q.delete(); left[1] = 1; i_we[1] = 1;
    i_addr[AW +: AW] = {2'd2, 13'h007, 9'h1FF}; i_wdata[DW +: DW] = 16'hA5A5; i_req[1] = 1;
    repeat (45) drive_cycle(0);
    t = find_cmd(ACT, 0);
    le = ent_at(t + 3); chk("t2 wr cmd", 32'(le.cmd), 32'(WR)); chk("t2 wr oe", 32'(le.oe), 1);
    chk("t2 wdata", 32'(le.wdata), 32'hA5A5); chk("t2 wr col", 32'(le.addr), 32'h1FF);
    le = ent_at(t + 5); chk("t2 pre cmd", 32'(le.cmd), 32'(PRE));
    n = 0; foreach (log_q[i]) if (log_q[i].oe) n++;
    chk("t2 oe cycles", 32'(n), 1);

    // Both ports writing continuously.
    log_q.delete(); left[0] = 2; left[1] = 2; i_we = 2'b11; i_req = 2'b11;
    repeat (45) drive_cycle(0);
    acts.delete(); gs.delete();
    foreach (log_q[i]) if (log_q[i].cmd == ACT) begin acts.push_back(log_q[i].cyc); gs.push_back(log_q[i].gnt); end
    chk("t3 act count", 32'(acts.size()), 4);
    if (acts.size() == 4) begin
      for (int k = 0; k < 4; k++) chk("t3 gnt order", 32'(gs[k]), (k % 2) ? 2 : 1);
      for (int k = 1; k < 4; k++) chk("t3 act spacing", 32'(acts[k] - acts[k-1]), 8);
    end

    // Refresh and port0 together.
    log_q.delete(); left[0] = 1; i_we[0] = 0; i_req[0] = 1; i_refresh_req = 1;
    repeat (45) drive_cycle(0);
    r = find_cmd(REF, 0); le = ent_at(r);
    chk("t4 ref ack", 32'(le.ack), 1);
    le = ent_at(r + 9); chk("t4 act after ref", 32'(le.cmd), 32'(ACT)); chk("t4 act gnt", 32'(le.gnt), 1);
    n = 0; foreach (log_q[i]) if (log_q[i].ack) n++;
    chk("t4 ack cycles", 32'(n), 1);

    // Refresh and port1 arriving during a port0 read.
    log_q.delete(); left[0] = 1; i_we[0] = 0; i_addr[0 +: AW] = {2'd0, 13'h0AA, 9'h011}; i_req[0] = 1;
    wait_act(t);
    drive_cycle(0);
    i_refresh_req = 1; left[1] = 1; i_we[1] = 1; i_req[1] = 1;
    repeat (45) drive_cycle(0);
    le = ent_at(t + 7); chk("t5 pre", 32'(le.cmd), 32'(PRE));
    chk("t5 ref cycle", 32'(find_cmd(REF, 0)), 32'(t + 10));
    le = ent_at(t + 19); chk("t5 port1 act", 32'(le.cmd), 32'(ACT)); chk("t5 port1 gnt", 32'(le.gnt), 2);

    // Reset in the middle of a read, then init_done held low.
    log_q.delete(); left[0] = 1; i_we[0] = 0; i_addr[0 +: AW] = {2'd3, 13'h055, 9'h012}; i_req[0] = 1;
    wait_act(t);
    repeat (4) drive_cycle(0);
    i_rst = 1; i_init_done = 0; #1;
    chk("t6 async cmd", 32'(o_cmd), 0); chk("t6 async ba", 32'(o_ba), 0);
    chk("t6 async addr", 32'(o_addr), 0); chk("t6 async rvalid", 32'(o_rvalid), 0);
    left[0] = 1; i_req[0] = 1;
    repeat (2) drive_cycle(0);
    i_rst = 0; log_q.delete();
    repeat (20) drive_cycle(0);
    chk("t6 quiet while !init", 32'(log_q.size()), 0);
    i_init_done = 1;
    repeat (20) drive_cycle(0);

    repeat (4000) drive_cycle(1);
    i_init_done = 1; i_req = 0; i_refresh_req = 0;
    repeat (40) drive_cycle(0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
